// File: rtl/tm_stim_pkg.sv
// Shared types and helpers for the Tsetlin Machine stimulus sequencer.
//   - state_t   : sequencer FSM states
//   - PKG_*     : default vector geometry (62 DUT bits plus one DUT reset bit)
//   - popcount  : bit count of a vector up to POP_MAX_W bits wide
package tm_stim_pkg;

  localparam int PKG_DATA_W  = 62;
  localparam int PKG_VEC_W   = PKG_DATA_W + 1;
  localparam int PKG_RST_BIT = PKG_DATA_W;

  // popcount operates on a fixed-width operand; narrower callers zero-extend
  localparam int POP_MAX_W = 256;
  localparam int POP_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_HOLD,
    ST_FINISH
  } state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      c = c + POP_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/tm_toggle_accum.sv
// Output toggle accumulator.
// Keeps the previously sampled DUT output word and adds the number of bits
// that differ from it to a saturating counter whenever en is high.
//   clk, rst  : clock, asynchronous active-low reset (counter only)
//   clr       : zero the counter and capture sample as the new reference
//   en        : accumulate popcount(sample ^ prev_out), then capture sample
//   sample    : DUT output word
//   cnt       : saturating toggle count
module tm_toggle_accum
  import tm_stim_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  output logic [CNT_W-1:0]  cnt
);

  localparam int SUM_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [DATA_W-1:0] prev_out;
  logic [POP_W-1:0]  flips;

  assign flips = popcount(POP_MAX_W'(sample ^ prev_out));

  // Any carry above the counter width pins the result at all-ones
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [POP_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (|s[SUM_W-1:CNT_W]) return '1;
    return s[CNT_W-1:0];
  endfunction

  // Reference word: only meaningful once a run has cleared it
  always_ff @(posedge clk) begin
    if (clr || en) prev_out <= sample;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_add(cnt, flips);
    end
  end

endmodule

// File: rtl/tm_stim_sequencer.sv
// Stimulus replay controller for power characterisation of Tsetlin Machine
// netlists. Reads vectors from a synchronous-read memory, drives each one onto
// the DUT inputs and DUT reset for a programmable hold, and counts DUT output
// bit toggles sampled at the end of every hold.
//   clk, rst          : clock, asynchronous active-low reset
//   start, abort      : begin a run (IDLE only) / terminate a run (any state)
//   num_vec, loop_en,
//   hold_cycles       : run configuration, captured when start is accepted
//   mem_rd_en/addr    : memory read strobe and address
//   mem_rdata         : memory word, {dut reset bit, dut inputs}, 1-cycle latency
//   dut_in, dut_rst   : registered DUT stimulus (dut_rst active-high)
//   dut_out           : DUT response
//   busy, done        : run in progress / one-cycle completion pulse
//   vec_idx           : index of the vector currently applied
//   toggle_cnt        : saturating output toggle count
module tm_stim_sequencer
  import tm_stim_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W,
  parameter int VEC_W  = DATA_W + 1,
  parameter int DEPTH  = 1000,
  parameter int ADDR_W = 10,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   num_vec,
  input  logic              loop_en,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VEC_W-1:0]  mem_rdata,
  output logic [DATA_W-1:0] dut_in,
  output logic              dut_rst,
  input  logic [DATA_W-1:0] dut_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] vec_idx,
  output logic [CNT_W-1:0]  toggle_cnt
);

  localparam int              RST_BIT = VEC_W - 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  state_t              state, state_nx;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     nv_lat;
  logic                loop_lat;
  logic [HOLD_W-1:0]   hold_lat;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                start_acc;
  logic                hold_last;
  logic                last_vec;
  logic                acc_en;

  function automatic logic [ADDR_W:0] clamp_num(input logic [ADDR_W:0] n);
    return (n > DEPTH_L) ? DEPTH_L : n;
  endfunction

  function automatic logic [HOLD_W-1:0] hold_norm(input logic [HOLD_W-1:0] h);
    return (h == '0) ? HOLD_W'(1) : h;
  endfunction

  assign start_acc = (state == ST_IDLE) && start && !abort;
  assign hold_last = (hold_cnt <= HOLD_W'(1));
  assign last_vec  = ({1'b0, idx} == (nv_lat - ONE_L));
  assign acc_en    = (state == ST_HOLD) && hold_last && !abort;
  // idx is always below the clamped vector count, so the address stays in range
  assign mem_addr  = idx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = (num_vec == '0) ? ST_FINISH : ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_en = 1'b1;
        busy      = 1'b1;
        state_nx  = ST_APPLY;
      end
      ST_APPLY: begin
        busy     = 1'b1;
        state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        busy = 1'b1;
        if (hold_last) state_nx = (last_vec && !loop_lat) ? ST_FINISH : ST_FETCH;
      end
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    // abort overrides every transition, including a simultaneous start
    if (abort) state_nx = ST_IDLE;
  end

  // Run control: configuration capture, vector index, hold countdown
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx      <= '0;
      nv_lat   <= '0;
      loop_lat <= 1'b0;
      hold_lat <= HOLD_W'(1);
      hold_cnt <= HOLD_W'(1);
    end else if (!abort) begin
      if (start_acc) begin
        idx      <= '0;
        nv_lat   <= clamp_num(num_vec);
        loop_lat <= loop_en;
        hold_lat <= hold_norm(hold_cycles);
      end
      if (state == ST_APPLY) begin
        hold_cnt <= hold_lat;
      end else if (state == ST_HOLD && !hold_last) begin
        hold_cnt <= hold_cnt - HOLD_W'(1);
      end
      if (state == ST_HOLD && hold_last && !(last_vec && !loop_lat)) begin
        idx <= last_vec ? '0 : idx + ADDR_W'(1);
      end
    end
  end

  // Memory word -> DUT stimulus; DUT goes back into reset when a run ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dut_in  <= '0;
      dut_rst <= 1'b1;
      vec_idx <= '0;
    end else if (abort || state_nx == ST_FINISH) begin
      dut_rst <= 1'b1;
    end else if (state == ST_APPLY) begin
      dut_rst <= mem_rdata[RST_BIT];
      dut_in  <= mem_rdata[DATA_W-1:0];
      vec_idx <= idx;
    end
  end

  tm_toggle_accum #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_toggle_accum (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_acc),
    .en     (acc_en),
    .sample (dut_out),
    .cnt    (toggle_cnt)
  );

endmodule

// File: tb/tb_tm_stim_sequencer.sv
// Scoreboard bench for tm_stim_sequencer: a memory model and a loopback DUT
// (dut_out = dut_in). Directed runs push expected read addresses and expected
// completion (cycle, toggle count) into queues; a monitor pops and compares.
module tb_tm_stim_sequencer;

  localparam int DATA_W = 62;
  localparam int VEC_W  = DATA_W + 1;
  localparam int DEPTH  = 1000;
  localparam int ADDR_W = 10;
  localparam int HOLD_W = 8;
  localparam int CNT_W  = 8;
  localparam logic [DATA_W-1:0] ONES = '1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   num_vec = '0;
  logic              loop_en = 1'b0;
  logic [HOLD_W-1:0] hold_cycles = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [VEC_W-1:0]  mem_rdata = '0;
  logic [DATA_W-1:0] dut_in;
  logic              dut_rst;
  logic [DATA_W-1:0] dut_out;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] vec_idx;
  logic [CNT_W-1:0]  toggle_cnt;

  logic [VEC_W-1:0]  mem [DEPTH];

  typedef struct {
    int               c;
    logic [CNT_W-1:0] tog;
  } done_t;

  int                tests = 0;
  int                fails = 0;
  int                cyc = 0;
  int                addr_q[$];
  done_t             done_q[$];
  logic [DATA_W-1:0] last_in = '0;

  tm_stim_sequencer #(
    .DATA_W (DATA_W), .VEC_W (VEC_W), .DEPTH (DEPTH),
    .ADDR_W (ADDR_W), .HOLD_W (HOLD_W), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .num_vec (num_vec), .loop_en (loop_en), .hold_cycles (hold_cycles),
    .mem_rd_en (mem_rd_en), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .dut_in (dut_in), .dut_rst (dut_rst), .dut_out (dut_out),
    .busy (busy), .done (done), .vec_idx (vec_idx), .toggle_cnt (toggle_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];
  assign dut_out = dut_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required bench completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    done_t d;
    if (rst) begin
      if (mem_rd_en) begin
        chk("addr_in_range", 64'(mem_addr < DEPTH), 1);
        chk("read_expected", 64'(addr_q.size() != 0), 1);
        if (addr_q.size() != 0) chk("read_addr", mem_addr, addr_q.pop_front());
      end
      if (done) begin
        chk("done_expected", 64'(done_q.size() != 0), 1);
        chk("done_busy_low", busy, 0);
        if (done_q.size() != 0) begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d.c);
          chk("done_toggle", toggle_cnt, d.tog);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Expected toggle count of a non-looping run of n vectors
  task automatic model(input int n, output logic [CNT_W-1:0] tog);
    int acc = 0;
    int m = (n > DEPTH) ? DEPTH : n;
    for (int k = 0; k < m; k++) begin
      acc += $countones(mem[k][DATA_W-1:0] ^ last_in);
      last_in = mem[k][DATA_W-1:0];
    end
    if (acc > (1 << CNT_W) - 1) acc = (1 << CNT_W) - 1;
    tog = CNT_W'(acc);
  endtask

  task automatic launch(input int n, input logic lp, input int h);
    num_vec     = (ADDR_W+1)'(n);
    loop_en     = lp;
    hold_cycles = HOLD_W'(h);
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic std_run(input int n, input int h, output int t);
    logic [CNT_W-1:0] tog;
    done_t d;
    int m = (n > DEPTH) ? DEPTH : n;
    int per = ((h == 0) ? 1 : h) + 2;
    t = cyc;
    for (int k = 0; k < m; k++) addr_q.push_back(k);
    model(n, tog);
    d.c   = t + 1 + m * per;
    d.tog = tog;
    done_q.push_back(d);
    launch(n, 1'b0, h);
  endtask

  task automatic drain(input int limit);
    int w = 0;
    while (done_q.size() != 0 && w < limit) begin
      @(negedge clk);
      w++;
    end
    chk("run_completed", done_q.size(), 0);
    chk("reads_consumed", addr_q.size(), 0);
  endtask

  initial begin
    int t;
    int acc;
    logic [DATA_W-1:0] p;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_vec_idx", vec_idx, 0);
    chk("rst_toggle", toggle_cnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_rd_en", mem_rd_en, 0);
      chk("idle_busy", busy, 0);
      chk("idle_dut_rst", dut_rst, 1);
    end

    // Basic run: 4 vectors, hold 1, period 3, done at start+13, 125 toggles
    mem[0] = {1'b0, 62'h0};
    mem[1] = {1'b0, ONES};
    mem[2] = {1'b0, 62'h0};
    mem[3] = {1'b0, 62'h1};
    std_run(4, 1, t);
    chk("basic_busy", busy, 1);
    wait_until(t + 2);
    chk("basic_not_yet_applied", dut_in, 0);
    chk("basic_still_reset", dut_rst, 1);
    for (int k = 0; k < 4; k++) begin
      wait_until(t + 3 + 3 * k);
      chk("basic_dut_in", dut_in, mem[k][DATA_W-1:0]);
      chk("basic_dut_rst", dut_rst, 0);
      chk("basic_vec_idx", vec_idx, k);
    end
    drain(40);
    chk("basic_toggle_125", toggle_cnt, 125);
    chk("basic_end_dut_rst", dut_rst, 1);
    chk("basic_end_dut_in", dut_in, 62'h1);

    // Zero vectors: done at start+1, no reads
    std_run(0, 1, t);
    drain(10);
    chk("zero_toggle", toggle_cnt, 0);

    // Hold 5 with the DUT reset bit set on the middle vector
    mem[0] = {1'b0, 62'h5555};
    mem[1] = {1'b1, 62'hAAAA};
    mem[2] = {1'b0, 62'h1234};
    std_run(3, 5, t);
    wait_until(t + 9);
    chk("hold5_v0_rst", dut_rst, 0);
    for (int c = 10; c < 15; c++) begin
      wait_until(t + c);
      chk("hold5_v1_rst", dut_rst, 1);
      chk("hold5_v1_in", dut_in, 62'hAAAA);
    end
    wait_until(t + 17);
    chk("hold5_v2_rst", dut_rst, 0);
    chk("hold5_v2_in", dut_in, 62'h1234);
    drain(40);

    // hold_cycles = 0 behaves as 1
    std_run(2, 0, t);
    wait_until(t + 3);
    chk("hold0_v0", dut_in, 62'h5555);
    wait_until(t + 6);
    chk("hold0_v1", dut_in, 62'hAAAA);
    drain(20);

    // Looping run, ignored start, abort at the first HOLD cycle of vector 4
    mem[0] = {1'b0, 62'h3};
    mem[1] = {1'b0, 62'h3C};
    t = cyc;
    for (int k = 0; k < 5; k++) addr_q.push_back(k % 2);
    p = last_in;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      acc += $countones(mem[k % 2][DATA_W-1:0] ^ p);
      p = mem[k % 2][DATA_W-1:0];
    end
    launch(2, 1'b1, 3);
    wait_until(t + 8);
    num_vec = '0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("loop_start_ignored", busy, 1);
    wait_until(t + 23);
    chk("loop_pre_abort_busy", busy, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dut_rst", dut_rst, 1);
    chk("abort_rd_en", mem_rd_en, 0);
    chk("abort_toggle", toggle_cnt, acc);
    chk("abort_dut_in", dut_in, 62'h3);
    last_in = mem[0][DATA_W-1:0];
    repeat (6) @(negedge clk);
    chk("abort_reads_consumed", addr_q.size(), 0);
    chk("abort_stays_idle", busy, 0);

    // start and abort together in IDLE: nothing starts
    num_vec = 11'd2;
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    chk("start_abort_idle", busy, 0);
    chk("start_abort_toggle", toggle_cnt, acc);

    // Clamp: 1023 requested, 1000 applied, last address 999
    for (int i = 0; i < DEPTH; i++) mem[i] = (i % 2 == 1) ? {1'b0, ONES} : '0;
    std_run(1023, 1, t);
    drain(3100);
    chk("clamp_vec_idx", vec_idx, 999);
    chk("clamp_toggle_sat", toggle_cnt, 255);

    // Saturation: alternating 0 / all-ones over 10 vectors holds at 255
    std_run(10, 1, t);
    drain(60);
    chk("sat_toggle", toggle_cnt, 255);
    chk("sat_vec_idx", vec_idx, 9);

    // Asynchronous reset in the middle of a run
    std_run(4, 1, t);
    wait_until(t + 7);
    #2 rst = 1'b0;
    #1;
    chk("arst_dut_rst", dut_rst, 1);
    chk("arst_dut_in", dut_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_rd_en", mem_rd_en, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_vec_idx", vec_idx, 0);
    chk("arst_toggle", toggle_cnt, 0);
    addr_q.delete();
    done_q.delete();
    last_in = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_after_busy", busy, 0);
    chk("arst_after_rd_en", mem_rd_en, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
